// File: rtl/st_pkg.sv
// Shared definitions for the Avalon-ST width converters (sts2stl, stl2sts, st2mm).
// Contents:
//   st_state_e  - packing FSM state encoding (S_IDLE, S_HI, S_LO)
//   half_empty  - empty-symbol count of a word whose lower half is padding
//   HALF_EMPTY  - half_empty() evaluated for the default 32-bit word
package st_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no packet open
    S_HI   = 2'd1,  // packet open, next half-word is the upper half
    S_LO   = 2'd2   // upper half held, next half-word completes the word
  } st_state_e;

  // Number of unused 8-bit symbols when only the upper half of a word carries data.
  function automatic int unsigned half_empty(input int unsigned bitsize);
    return bitsize / 16;
  endfunction

  localparam int unsigned HALF_EMPTY = half_empty(32);

endpackage

// File: rtl/sts2stl.sv
// sts2stl: Avalon-ST width packer, BITSIZE/2-bit half-words in, BITSIZE-bit words out.
// The first half-word of each pair lands in the upper half of the output word. An odd
// packet length ends with a padded word (lower half zero) and empty = BITSIZE/16.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   data_in_*                Avalon-ST sink (data/valid/ready/sop/eop), ready latency 0
//   data_out_*               Avalon-ST source (data/valid/ready/empty/sop/eop), one register
//   proto_err                sticky protocol-error flag, only when STS2STL_ERR_EN is defined
//
// Configuration macro: STS2STL_ERR_EN adds the proto_err output. Discard/restart handling
// of malformed packets is the same with or without it.
module sts2stl
  import st_pkg::*;
#(
  parameter int unsigned BITSIZE    = 32,
  parameter int unsigned EMPTY_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITSIZE/2-1:0]    data_in_data,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  input  logic                    data_in_startofpacket,
  input  logic                    data_in_endofpacket,
  output logic [BITSIZE-1:0]      data_out_data,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic [EMPTY_SIZE-1:0]   data_out_empty,
  output logic                    data_out_startofpacket,
  output logic                    data_out_endofpacket
`ifdef STS2STL_ERR_EN
  ,
  output logic                    proto_err
`endif
);

  localparam int unsigned HalfW     = BITSIZE / 2;
  localparam int unsigned HalfEmpty = half_empty(BITSIZE);

  st_state_e             state_q, state_d;
  logic [HalfW-1:0]      hi_q, hi_d;
  logic                  sop_pending_q, sop_pending_d;
  logic [BITSIZE-1:0]    out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [EMPTY_SIZE-1:0] out_empty_q, out_empty_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;

  logic in_fire;

  // The output stage can take a word now if it is empty or being drained this cycle.
  assign data_in_ready = !out_valid_q || data_out_ready;
  assign in_fire       = data_in_valid && data_in_ready;

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    sop_pending_d = sop_pending_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_empty_d   = out_empty_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;

    if (out_valid_q && data_out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (data_in_startofpacket) begin
        // A sop always starts a fresh packet; anything held from an open packet is dropped.
        if (data_in_endofpacket) begin
          out_data_d    = {data_in_data, {HalfW{1'b0}}};
          out_valid_d   = 1'b1;
          out_empty_d   = EMPTY_SIZE'(HalfEmpty);
          out_sop_d     = 1'b1;
          out_eop_d     = 1'b1;
          sop_pending_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          hi_d          = data_in_data;
          sop_pending_d = 1'b1;
          state_d       = S_LO;
        end
      end else begin
        unique case (state_q)
          S_HI: begin
            if (data_in_endofpacket) begin
              out_data_d  = {data_in_data, {HalfW{1'b0}}};
              out_valid_d = 1'b1;
              out_empty_d = EMPTY_SIZE'(HalfEmpty);
              out_sop_d   = 1'b0;
              out_eop_d   = 1'b1;
              state_d     = S_IDLE;
            end else begin
              hi_d    = data_in_data;
              state_d = S_LO;
            end
          end
          S_LO: begin
            out_data_d    = {hi_q, data_in_data};
            out_valid_d   = 1'b1;
            out_empty_d   = '0;
            out_sop_d     = sop_pending_q;
            out_eop_d     = data_in_endofpacket;
            sop_pending_d = 1'b0;
            state_d       = data_in_endofpacket ? S_IDLE : S_HI;
          end
          default: begin
            // Non-sop beat with no packet open: dropped.
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hi_q          <= '0;
      sop_pending_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_empty_q   <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      sop_pending_q <= sop_pending_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_empty_q   <= out_empty_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
    end
  end

  assign data_out_data          = out_data_q;
  assign data_out_valid         = out_valid_q;
  assign data_out_empty         = out_empty_q;
  assign data_out_startofpacket = out_sop_q;
  assign data_out_endofpacket   = out_eop_q;

`ifdef STS2STL_ERR_EN
  logic proto_err_q, proto_err_d, err_set;

  // Error: non-sop beat with no packet open, or sop while a packet is still open.
  always_comb begin
    err_set     = in_fire && ((state_q == S_IDLE) != data_in_startofpacket);
    proto_err_d = proto_err_q || err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_sts2stl.sv
// Self-checking bench for sts2stl: directed vector table, hand-written corner sequences
// and a randomized run checked against a packet-level reference model.
module tb_sts2stl;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [31:0] dout;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [1:0]  out_empty;
`ifdef STS2STL_ERR_EN
  logic        proto_err;
`endif

  int checks = 0;
  int errors = 0;

  sts2stl #(
    .BITSIZE    (32),
    .EMPTY_SIZE (2)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .data_in_data           (din),
    .data_in_valid          (in_valid),
    .data_in_ready          (in_ready),
    .data_in_startofpacket  (in_sop),
    .data_in_endofpacket    (in_eop),
    .data_out_data          (dout),
    .data_out_valid         (out_valid),
    .data_out_ready         (out_ready),
    .data_out_empty         (out_empty),
    .data_out_startofpacket (out_sop),
    .data_out_endofpacket   (out_eop)
`ifdef STS2STL_ERR_EN
    ,
    .proto_err              (proto_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- directed vectors
  typedef struct {
    bit          v, s, e;
    logic [15:0] d;
    bit          r;
    bit          exp_in_ready;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_sop, exp_eop;
    logic [1:0]  exp_empty;
  } vec_t;

  vec_t vecs[20];

  task automatic drive(input bit v, input bit s, input bit e, input logic [15:0] d,
                       input bit r);
    in_valid  = v;
    in_sop    = s;
    in_eop    = e;
    din       = d;
    out_ready = r;
  endtask

  task automatic cyc(input bit v, input bit s, input bit e, input logic [15:0] d,
                     input bit r);
    drive(v, s, e, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [31:0] d, input bit s,
                          input bit e, input logic [1:0] m);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, dout, d);
    chk({name, "_sop_eop_empty"}, {28'd0, out_sop, out_eop, out_empty}, {28'd0, s, e, m});
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct {
    logic [31:0] d;
    logic        s, e;
    logic [1:0]  m;
  } word_t;

  word_t       exp_q[$];
  word_t       act_q[$];
  logic [15:0] cur[$];
  bit          open_pkt = 0;
  bit          model_err = 0;
  bit          mon_en = 0;
  bit          rand_rdy_en = 0;

  // Words of the current packet: the first nw pairs, the last one possibly padded.
  function automatic void emit(input int nw, input bit terminated);
    int n = cur.size();
    for (int i = 0; i < nw; i++) begin
      word_t w;
      w.d = {cur[2*i], (2*i+1 < n) ? cur[2*i+1] : 16'h0000};
      w.s = (i == 0);
      w.e = terminated && (i == nw - 1);
      w.m = (w.e && (n % 2 == 1)) ? 2'd2 : 2'd0;
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_beat(input bit s, input bit e, input logic [15:0] d);
    if (s) begin
      if (open_pkt) begin
        model_err = 1;
        emit(cur.size() / 2, 0);  // aborted packet: only completed pairs ever went out
      end
      cur.delete();
      open_pkt = 1;
    end else if (!open_pkt) begin
      model_err = 1;
      return;
    end
    cur.push_back(d);
    if (e) begin
      emit((cur.size() + 1) / 2, 1);
      cur.delete();
      open_pkt = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) act_q.push_back('{dout, out_sop, out_eop, out_empty});
      if (in_valid && in_ready) model_beat(in_sop, in_eop, din);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input bit s, input bit e, input logic [15:0] d);
    bit done = 0;
    int n = 0;
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    din      = d;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 for %0d cycles, expected acceptance", n);
    end
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    rst = 1'b1;
    drive(L, L, L, 16'h0, L);

    //              v  s  e  data     r  eir ev  exp_data      es ee em
    vecs[0]  = '{H, H, L, 16'h0001, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[1]  = '{H, L, L, 16'h0002, H, H, H, 32'h00010002, H, L, 2'd0};
    vecs[2]  = '{H, L, L, 16'h0003, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[3]  = '{H, L, L, 16'h0004, H, H, H, 32'h00030004, L, L, 2'd0};
    vecs[4]  = '{H, L, L, 16'h0005, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[5]  = '{H, L, H, 16'h0006, H, H, H, 32'h00050006, L, H, 2'd0};
    vecs[6]  = '{H, H, L, 16'h0001, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[7]  = '{H, L, L, 16'h0002, H, H, H, 32'h00010002, H, L, 2'd0};
    vecs[8]  = '{H, L, L, 16'h0003, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[9]  = '{H, L, L, 16'h0004, H, H, H, 32'h00030004, L, L, 2'd0};
    vecs[10] = '{H, L, H, 16'h0005, H, H, H, 32'h00050000, L, H, 2'd2};
    vecs[11] = '{H, H, H, 16'hABCD, H, H, H, 32'hABCD0000, H, H, 2'd2};
    vecs[12] = '{H, H, L, 16'h0100, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[13] = '{H, L, L, 16'h0101, L, H, H, 32'h01000101, H, L, 2'd0};
    vecs[14] = '{H, L, L, 16'h0102, L, L, H, 32'h01000101, H, L, 2'd0};
    vecs[15] = '{H, L, L, 16'h0102, L, L, H, 32'h01000101, H, L, 2'd0};
    vecs[16] = '{H, L, L, 16'h0102, L, L, H, 32'h01000101, H, L, 2'd0};
    vecs[17] = '{H, L, L, 16'h0102, H, H, L, 32'h0,        L, L, 2'd0};
    vecs[18] = '{H, L, H, 16'h0103, H, H, H, 32'h01020103, L, H, 2'd0};
    vecs[19] = '{L, L, L, 16'h0000, H, H, L, 32'h0,        L, L, 2'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {dout[31:0]}, 32'h0);
    chk("reset_flags", {27'd0, out_valid, out_sop, out_eop, out_empty}, 32'h0);
`ifdef STS2STL_ERR_EN
    chk("reset_proto_err", {31'd0, proto_err}, 32'h0);
`endif
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].r);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_in_ready});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), dout, vecs[i].exp_data);
        chk($sformatf("vec%0d_flags", i), {28'd0, out_sop, out_eop, out_empty},
            {28'd0, vecs[i].exp_sop, vecs[i].exp_eop, vecs[i].exp_empty});
      end
    end

    // Non-sop beat with no packet open is dropped.
    cyc(H, L, L, 16'h0055, H);
    cyc(L, L, L, 16'h0000, H);
    chk("stray_dropped", {31'd0, out_valid}, 32'd0);
`ifdef STS2STL_ERR_EN
    chk("stray_proto_err", {31'd0, proto_err}, 32'd1);
    rst = 1'b1;
    cyc(L, L, L, 16'h0000, H);
    rst = 1'b0;
    chk("proto_err_rst", {31'd0, proto_err}, 32'd0);
`endif

    // sop while a half-word is held: held half dropped, new packet restarts.
    cyc(H, H, L, 16'h0001, H);
    cyc(H, L, L, 16'h0002, H);
    chk_word("restart_w0", 32'h00010002, 1'b1, 1'b0, 2'd0);
    cyc(H, L, L, 16'h0003, H);
    cyc(H, H, L, 16'h0004, H);
    chk("restart_no_word", {31'd0, out_valid}, 32'd0);
    cyc(H, L, H, 16'h0005, H);
    chk_word("restart_w1", 32'h00040005, 1'b1, 1'b1, 2'd0);
    cyc(L, L, L, 16'h0000, H);
`ifdef STS2STL_ERR_EN
    chk("restart_proto_err", {31'd0, proto_err}, 32'd1);
    repeat (3) cyc(L, L, L, 16'h0000, H);
    chk("proto_err_sticky", {31'd0, proto_err}, 32'd1);
`endif

    // Reset while in S_LO clears every output register.
    cyc(H, H, L, 16'h0020, H);
    cyc(H, L, L, 16'h0021, L);
    chk_word("prerst_word", 32'h00200021, 1'b1, 1'b0, 2'd0);
    cyc(H, L, L, 16'h0022, H);
    rst = 1'b1;
    cyc(L, L, L, 16'h0000, H);
    rst = 1'b0;
    chk("midrst_data", dout, 32'h0);
    chk("midrst_flags", {27'd0, out_valid, out_sop, out_eop, out_empty}, 32'h0);
`ifdef STS2STL_ERR_EN
    chk("midrst_proto_err", {31'd0, proto_err}, 32'd0);
`endif
    cyc(H, H, L, 16'h0010, H);
    cyc(H, L, H, 16'h0011, H);
    chk_word("postrst_word", 32'h00100011, 1'b1, 1'b1, 2'd0);
    cyc(L, L, L, 16'h0000, H);

    // Randomized packets with random backpressure and occasional protocol errors.
    rst = 1'b1;
    cyc(L, L, L, 16'h0000, H);
    rst = 1'b0;
    mon_en      = 1;
    rand_rdy_en = 1;
    for (int p = 0; p < 60; p++) begin
      int  len   = $urandom_range(1, 7);
      bit  trunc = (p != 59) && (len > 1) && ($urandom_range(0, 7) == 0);
      int  nb    = trunc ? $urandom_range(1, len - 1) : len;
      if ($urandom_range(0, 7) == 0) send(1'b0, 1'b0, 16'($urandom));
      for (int b = 0; b < nb; b++) begin
        send(b == 0, !trunc && (b == len - 1), 16'($urandom));
      end
    end
    repeat (20) @(posedge clk);
    rand_rdy_en = 0;
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mon_en = 0;

    chk("rand_word_count", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("rand_w%0d_data", i), act_q[i].d, exp_q[i].d);
      chk($sformatf("rand_w%0d_flags", i), {28'd0, act_q[i].s, act_q[i].e, act_q[i].m},
          {28'd0, exp_q[i].s, exp_q[i].e, exp_q[i].m});
    end
`ifdef STS2STL_ERR_EN
    chk("rand_proto_err", {31'd0, proto_err}, {31'd0, model_err});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
